// File: rtl/freq_uart_reporter.sv
// Snapshots four 32-bit frequency channels and sends them as a framed UART packet,
// periodically and on request. Define FREQ_REPORT_CSUM_EN to append a checksum byte.
module freq_uart_reporter #(
  parameter int CLK_HZ     = 20000000,
  parameter int BAUD       = 115200,
  parameter int PERIOD_CYC = 20000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] freq_in_0,
  input  logic [31:0] freq_in_1,
  input  logic [31:0] freq_in_2,
  input  logic [31:0] freq_in_3,
  input  logic        report_req,
  output logic        tx,
  output logic        busy
);
  // BAUD_DIV must be at least 2: the stop bit's last cycle is spent in NEXT.
  localparam int BAUD_DIV = CLK_HZ / BAUD;
`ifdef FREQ_REPORT_CSUM_EN
  localparam int PKT_LEN  = 19;
`else
  localparam int PKT_LEN  = 18;
`endif
  localparam int TW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int IW = $clog2(PKT_LEN + 1);
  localparam int PW = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_DATA, S_STOP, S_NEXT} state_t;

  state_t            r_state, w_next;
  logic [PW-1:0]     r_per;
  logic              r_pend;
  logic [TW-1:0]     r_tmr;
  logic [2:0]        r_bit;
  logic [IW-1:0]     r_idx;
  logic [15:0][7:0]  r_snap;

  logic              w_auto, w_load, w_bit_end, w_stop_end, w_last;
  logic [3:0]        w_k;
  logic [7:0]        w_byte;

  assign w_auto     = (r_per == PW'(PERIOD_CYC - 1));
  assign w_load     = (r_state == S_IDLE) && r_pend;
  assign w_bit_end  = (r_tmr == TW'(BAUD_DIV - 1));
  assign w_stop_end = (r_tmr == TW'(BAUD_DIV - 2));
  assign w_last     = (r_idx == IW'(PKT_LEN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (r_pend) w_next = S_LOAD;
      S_LOAD:  w_next = S_START;
      S_START: if (w_bit_end) w_next = S_DATA;
      S_DATA:  if (w_bit_end && r_bit == 3'd7) w_next = S_STOP;
      S_STOP:  if (w_stop_end) w_next = S_NEXT;
      S_NEXT:  w_next = w_last ? S_IDLE : S_START;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_per  <= '0;
      r_pend <= 1'b0;
      r_tmr  <= '0;
      r_bit  <= '0;
      r_idx  <= '0;
      r_snap <= '0;
    end else begin
      r_per  <= w_auto ? '0 : r_per + 1'b1;
      // Triggers seen in the IDLE->LOAD cycle are served by the packet about to load.
      r_pend <= w_load ? 1'b0 : (r_pend | w_auto | report_req);
      case (r_state)
        S_LOAD: begin
          r_snap <= {freq_in_0, freq_in_1, freq_in_2, freq_in_3};
          r_idx  <= '0;
          r_tmr  <= '0;
          r_bit  <= '0;
        end
        S_START: r_tmr <= w_bit_end ? '0 : r_tmr + 1'b1;
        S_DATA: begin
          r_tmr <= w_bit_end ? '0 : r_tmr + 1'b1;
          if (w_bit_end) r_bit <= r_bit + 3'd1;
        end
        S_STOP:  r_tmr <= w_stop_end ? '0 : r_tmr + 1'b1;
        S_NEXT:  r_idx <= r_idx + 1'b1;
        default: ;
      endcase
    end
  end

`ifdef FREQ_REPORT_CSUM_EN
  logic [7:0] w_csum;
  always_comb begin
    w_csum = '0;
    for (int k = 0; k < 16; k++) w_csum = w_csum + r_snap[k];
  end
`endif

  // Packet byte n>=2 is snapshot byte n-2, counted from the MSB of channel 0.
  always_comb begin
    w_k    = 4'(r_idx - IW'(2));
    w_byte = r_snap[4'd15 - w_k];
    if (r_idx == IW'(0))      w_byte = 8'hA5;
    else if (r_idx == IW'(1)) w_byte = 8'h5A;
`ifdef FREQ_REPORT_CSUM_EN
    else if (w_last)          w_byte = w_csum;
`endif
  end

  always_comb begin
    tx = 1'b1;
    case (r_state)
      S_START: tx = 1'b0;
      S_DATA:  tx = w_byte[r_bit];
      default: tx = 1'b1;
    endcase
  end

  assign busy = (r_state != S_IDLE);

endmodule
